// File: rtl/keypad_scan_bcd_pkg.sv
// rtl/keypad_scan_bcd_pkg.sv - shared types, key codes and keymap for the keypad scanner
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_e;

  localparam logic [3:0] KEY_CLR    = 4'hA;
  localparam logic [3:0] KEY_BSP    = 4'hB;
  localparam int         BCD_DIGITS = 4;

  // Row 3 carries '*' as E and '#' as F so that C..F are all non-editing keys.
  function automatic logic [3:0] key_decode(input logic [1:0] row_idx, input logic [1:0] col_idx);
    logic [3:0] code;
    case ({row_idx, col_idx})
      4'h0:    code = 4'h1;
      4'h1:    code = 4'h2;
      4'h2:    code = 4'h3;
      4'h3:    code = 4'hA;
      4'h4:    code = 4'h4;
      4'h5:    code = 4'h5;
      4'h6:    code = 4'h6;
      4'h7:    code = 4'hB;
      4'h8:    code = 4'h7;
      4'h9:    code = 4'h8;
      4'hA:    code = 4'h9;
      4'hB:    code = 4'hC;
      4'hC:    code = 4'hE;
      4'hD:    code = 4'h0;
      4'hE:    code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  function automatic logic [3:0] col_onecold(input logic [1:0] col_idx);
    return ~(4'b0001 << col_idx);
  endfunction

endpackage

// File: rtl/keypad_scan_bcd_if.sv
// rtl/keypad_scan_bcd_if.sv - keypad matrix pins and decoded key/BCD outputs
interface keypad_scan_bcd_if;
  import keypad_pkg::*;

  logic [3:0]                row_n;
  logic [3:0]                col_n;
  logic                      key_valid;
  logic [3:0]                key_code;
  logic                      key_held;
  logic [4*BCD_DIGITS-1:0]   bcd_value;

  modport master (
    input  row_n,
    output col_n, key_valid, key_code, key_held, bcd_value
  );

  modport slave (
    output row_n,
    input  col_n, key_valid, key_code, key_held, bcd_value
  );

endinterface

// File: rtl/keypad_scan_bcd_tick.sv
// rtl/keypad_scan_bcd_tick.sv - one-cycle scan tick every DIV clocks
module scan_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int             W    = $clog2(DIV);
  localparam logic [W-1:0]   LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_scan_bcd.sv
// rtl/keypad_scan_bcd.sv - 4x4 keypad scan, debounce, decode and 4-digit BCD entry register
module keypad_scan_bcd
  import keypad_pkg::*;
#(
  parameter int CLK_HZ         = 50000000,
  parameter int SCAN_HZ        = 1000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic               clk50,
  input  logic               sys_init_ctrl,
  keypad_scan_bcd_if.master  kp
);

  localparam int         SCAN_DIV  = CLK_HZ / SCAN_HZ;
  localparam logic [7:0] DEB_LIMIT = 8'(DEBOUNCE_TICKS);

  logic                    tick;
  logic [3:0]              row_meta_q, row_sync_q;
  state_e                  state_q;
  logic [1:0]              col_idx_q, row_lat_q;
  logic [7:0]              cnt_q;
  logic [3:0]              col_n_q;
  logic                    key_valid_q, key_held_q;
  logic [3:0]              key_code_q;
  logic [4*BCD_DIGITS-1:0] bcd_q, bcd_d;

  logic                    row_any;
  logic [1:0]              low_idx;
  logic [1:0]              col_next;
  logic [7:0]              cnt_inc;
  logic [3:0]              code_d;
  logic                    accept;

  scan_tick_gen #(.DIV(SCAN_DIV)) u_tick (
    .clk_i  (clk50),
    .rst_i  (sys_init_ctrl),
    .tick_o (tick)
  );

  always_ff @(posedge clk50 or posedge sys_init_ctrl) begin
    if (sys_init_ctrl) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= kp.row_n;
      row_sync_q <= row_meta_q;
    end
  end

  // Lowest-numbered low row wins when several rows are pulled down.
  always_comb begin
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_sync_q[i]) low_idx = 2'(i);
    end
  end

  assign row_any  = ~&row_sync_q;
  assign col_next = col_idx_q + 2'd1;
  assign cnt_inc  = cnt_q + 8'd1;
  // On an accept the lowest-low row always equals the latched row.
  assign code_d   = key_decode(low_idx, col_idx_q);

  assign accept = tick && row_any &&
                  (((state_q == ST_SCAN) && (DEB_LIMIT == 8'd1)) ||
                   ((state_q == ST_DEBOUNCE) && (low_idx == row_lat_q) && (cnt_inc == DEB_LIMIT)));

  always_comb begin
    bcd_d = bcd_q;
    if (code_d <= 4'd9) begin
      bcd_d = {bcd_q[4*BCD_DIGITS-5:0], code_d};
    end else if (code_d == KEY_CLR) begin
      bcd_d = '0;
    end else if (code_d == KEY_BSP) begin
      bcd_d = {4'h0, bcd_q[4*BCD_DIGITS-1:4]};
    end
  end

  always_ff @(posedge clk50 or posedge sys_init_ctrl) begin
    if (sys_init_ctrl) begin
      state_q     <= ST_SCAN;
      col_idx_q   <= 2'd0;
      row_lat_q   <= 2'd0;
      cnt_q       <= 8'd0;
      col_n_q     <= 4'b1110;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      key_held_q  <= 1'b0;
      bcd_q       <= '0;
    end else begin
      key_valid_q <= 1'b0;
      if (accept) begin
        state_q     <= ST_HELD;
        cnt_q       <= 8'd0;
        key_code_q  <= code_d;
        key_valid_q <= 1'b1;
        key_held_q  <= 1'b1;
        bcd_q       <= bcd_d;
      end
      if (tick && !accept) begin
        case (state_q)
          ST_SCAN: begin
            if (row_any) begin
              row_lat_q <= low_idx;
              cnt_q     <= 8'd1;
              state_q   <= ST_DEBOUNCE;
            end else begin
              col_idx_q <= col_next;
              col_n_q   <= col_onecold(col_next);
            end
          end
          ST_DEBOUNCE: begin
            if (row_any && (low_idx == row_lat_q)) begin
              cnt_q <= cnt_inc;
            end else begin
              state_q   <= ST_SCAN;
              cnt_q     <= 8'd0;
              col_idx_q <= col_next;
              col_n_q   <= col_onecold(col_next);
            end
          end
          ST_HELD: begin
            if (row_any) begin
              cnt_q <= 8'd0;
            end else if (cnt_inc == DEB_LIMIT) begin
              state_q    <= ST_SCAN;
              cnt_q      <= 8'd0;
              key_held_q <= 1'b0;
              col_idx_q  <= col_next;
              col_n_q    <= col_onecold(col_next);
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          default: state_q <= ST_SCAN;
        endcase
      end
    end
  end

  assign kp.col_n     = col_n_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_held  = key_held_q;
  assign kp.bcd_value = bcd_q;

endmodule

// File: tb/tb_keypad_scan_bcd.sv
// tb/tb_keypad_scan_bcd.sv - keypad scanner bench with a decimal-entry reference model
module tb_keypad_scan_bcd;

  localparam int DIV = 10;
  localparam int DEB = 3;
  localparam logic [3:0] KEYMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                         4'h4, 4'h5, 4'h6, 4'hB,
                                         4'h7, 4'h8, 4'h9, 4'hC,
                                         4'hE, 4'h0, 4'hF, 4'hD};

  logic clk50 = 1'b0;
  logic sys_init_ctrl = 1'b0;
  logic [3:0][3:0] pressed;
  logic [3:0] rv;
  bit cmp_en = 1'b0;
  int checks = 0;
  int errors = 0;
  int dut_pulses = 0;

  keypad_scan_bcd_if kp();

  keypad_scan_bcd #(.CLK_HZ(1000), .SCAN_HZ(100), .DEBOUNCE_TICKS(DEB)) dut (
    .clk50         (clk50),
    .sys_init_ctrl (sys_init_ctrl),
    .kp            (kp)
  );

  always #5 clk50 = ~clk50;

  // Physical keypad: a pressed key shorts its row to its column.
  always_comb begin
    rv = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if ((pressed[r] & ~kp.col_n) != 4'h0) rv[r] = 1'b0;
    end
  end
  assign kp.row_n = rv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the entered number is kept as a decimal integer.
  int m_pre, m_col, m_phase, m_row, m_cnt, m_value;
  logic [3:0] m_code, m_s1, m_s2;
  bit m_valid, m_held;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [3:0] rows_seen(input int col);
    logic [3:0] r;
    r = 4'hF;
    for (int i = 0; i < 4; i++) if (pressed[i][col]) r[i] = 1'b0;
    return r;
  endfunction

  task automatic m_accept(input int r);
    m_code  = KEYMAP[r * 4 + m_col];
    m_valid = 1'b1;
    m_held  = 1'b1;
    m_phase = 2;
    m_cnt   = 0;
    if (m_code <= 4'd9) m_value = (m_value * 10 + int'(m_code)) % 10000;
    else if (m_code == 4'hA) m_value = 0;
    else if (m_code == 4'hB) m_value = m_value / 10;
  endtask

  always @(posedge clk50 or posedge sys_init_ctrl) begin
    logic [3:0] seen;
    int low;
    bit tk;
    if (sys_init_ctrl) begin
      m_pre = 0; m_col = 0; m_phase = 0; m_row = 0; m_cnt = 0; m_value = 0;
      m_code = 4'h0; m_valid = 1'b0; m_held = 1'b0; m_s1 = 4'hF; m_s2 = 4'hF;
    end else begin
      seen  = m_s2;
      tk    = (m_pre == DIV - 1);
      m_s2  = m_s1;
      m_s1  = rows_seen(m_col);
      m_pre = (m_pre + 1) % DIV;
      m_valid = 1'b0;
      low = -1;
      for (int r = 3; r >= 0; r--) if (!seen[r]) low = r;
      if (tk) begin
        if (m_phase == 0) begin
          if (low >= 0) begin
            m_row = low; m_cnt = 1;
            if (DEB == 1) m_accept(low); else m_phase = 1;
          end else m_col = (m_col + 1) % 4;
        end else if (m_phase == 1) begin
          if (low == m_row) begin
            m_cnt++;
            if (m_cnt == DEB) m_accept(low);
          end else begin
            m_phase = 0; m_cnt = 0; m_col = (m_col + 1) % 4;
          end
        end else begin
          if (low < 0) begin
            m_cnt++;
            if (m_cnt == DEB) begin
              m_phase = 0; m_cnt = 0; m_held = 1'b0; m_col = (m_col + 1) % 4;
            end
          end else m_cnt = 0;
        end
      end
    end
  end

  always @(negedge clk50) begin
    logic [3:0] ec;
    if (kp.key_valid) dut_pulses++;
    if (cmp_en) begin
      ec = ~(4'b0001 << m_col);
      chk("col_n", kp.col_n, ec);
      chk("key_valid", kp.key_valid, m_valid);
      chk("key_code", kp.key_code, m_code);
      chk("key_held", kp.key_held, m_held);
      chk("bcd_value", kp.bcd_value, to_bcd(m_value));
    end
  end

  // Waits until the scan has just moved onto column c, so a press is seen on the next tick.
  task automatic align(input int c);
    int n = 0;
    while (!(m_col == c && m_pre == 0 && m_phase == 0)) begin
      @(negedge clk50);
      n++;
      if (n > 400) begin
        checks++; errors++;
        $display("FAIL align_timeout: column %0d not reached within %0d cycles", c, n);
        return;
      end
    end
  endtask

  task automatic press_key(input int r, input int c, input int hold, input int gap);
    align(c);
    pressed[r][c] = 1'b1;
    repeat (hold * DIV) @(negedge clk50);
    pressed[r][c] = 1'b0;
    repeat (gap * DIV) @(negedge clk50);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int rows_s2 [5] = '{0, 0, 0, 1, 1};
    int cols_s2 [5] = '{0, 1, 2, 0, 1};
    logic [15:0] exp_s2 [5] = '{16'h0001, 16'h0012, 16'h0123, 16'h1234, 16'h2345};
    logic [3:0] col_seq [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    pressed = '0;
    #1 sys_init_ctrl = 1'b1;
    repeat (3) @(negedge clk50);
    cmp_en = 1'b1;
    sys_init_ctrl = 1'b0;

    // 1. reset mid-count, then column walk
    repeat (20) @(posedge clk50);
    #1 chk("s1_col_two_steps", kp.col_n, 4'b1011);
    repeat (5) @(posedge clk50);
    #2 sys_init_ctrl = 1'b1;
    #1;
    chk("s1_rst_col", kp.col_n, 4'b1110);
    chk("s1_rst_bcd", kp.bcd_value, 16'h0000);
    chk("s1_rst_valid", kp.key_valid, 1'b0);
    @(negedge clk50) sys_init_ctrl = 1'b0;
    for (int k = 0; k < 4; k++) begin
      repeat (10) @(posedge clk50);
      #1 chk("s1_col_seq", kp.col_n, col_seq[k]);
    end
    @(negedge clk50);

    // 2. digit entry
    p0 = dut_pulses;
    for (int k = 0; k < 5; k++) begin
      press_key(rows_s2[k], cols_s2[k], 6, 5);
      chk("s2_bcd", kp.bcd_value, exp_s2[k]);
    end
    chk("s2_pulses", dut_pulses - p0, 5);
    chk("s2_code", kp.key_code, 4'h5);
    chk("s2_model_value", to_bcd(m_value), 16'h2345);

    // 3. bounce on key D
    p0 = dut_pulses;
    align(3);
    pressed[3][3] = 1'b1;
    repeat (2 * DIV) @(negedge clk50);
    pressed[3][3] = 1'b0;
    repeat (1 * DIV) @(negedge clk50);
    chk("s3_no_pulse_first_burst", dut_pulses - p0, 0);
    pressed[3][3] = 1'b1;
    repeat (6 * DIV) @(negedge clk50);
    pressed[3][3] = 1'b0;
    repeat (5 * DIV) @(negedge clk50);
    chk("s3_pulses", dut_pulses - p0, 1);
    chk("s3_code", kp.key_code, 4'hD);
    chk("s3_bcd", kp.bcd_value, 16'h2345);

    // 4. edit keys
    press_key(1, 3, 6, 5);
    chk("s4_bsp", kp.bcd_value, 16'h0234);
    p0 = dut_pulses;
    press_key(2, 3, 6, 5);
    chk("s4_c_pulse", dut_pulses - p0, 1);
    chk("s4_c_code", kp.key_code, 4'hC);
    chk("s4_c_bcd", kp.bcd_value, 16'h0234);
    press_key(0, 3, 6, 5);
    chk("s4_clr", kp.bcd_value, 16'h0000);

    // 5. hold 9, second key on the same column in row 1
    p0 = dut_pulses;
    align(2);
    pressed[2][2] = 1'b1;
    repeat (20 * DIV) @(negedge clk50);
    pressed[1][2] = 1'b1;
    repeat (30 * DIV) @(negedge clk50);
    chk("s5_held_while_pressed", kp.key_held, 1'b1);
    pressed[2][2] = 1'b0;
    pressed[1][2] = 1'b0;
    repeat (25) @(negedge clk50);
    chk("s5_held_before_release_done", kp.key_held, 1'b1);
    repeat (10) @(negedge clk50);
    chk("s5_held_cleared", kp.key_held, 1'b0);
    chk("s5_pulses", dut_pulses - p0, 1);
    chk("s5_code", kp.key_code, 4'h9);
    chk("s5_bcd", kp.bcd_value, 16'h0009);
    repeat (5 * DIV) @(negedge clk50);

    // 6. multi-row priority, then reset during debounce
    p0 = dut_pulses;
    align(0);
    pressed[0][0] = 1'b1;
    pressed[1][0] = 1'b1;
    repeat (6 * DIV) @(negedge clk50);
    pressed[0][0] = 1'b0;
    pressed[1][0] = 1'b0;
    repeat (5 * DIV) @(negedge clk50);
    chk("s6_pulses", dut_pulses - p0, 1);
    chk("s6_code", kp.key_code, 4'h1);
    chk("s6_bcd", kp.bcd_value, 16'h0091);
    p0 = dut_pulses;
    align(0);
    pressed[0][0] = 1'b1;
    repeat (15) @(negedge clk50);
    chk("s6_model_debouncing", m_phase, 1);
    #2 sys_init_ctrl = 1'b1;
    #1;
    chk("s6_rst_col", kp.col_n, 4'b1110);
    chk("s6_rst_bcd", kp.bcd_value, 16'h0000);
    chk("s6_rst_valid", kp.key_valid, 1'b0);
    chk("s6_rst_held", kp.key_held, 1'b0);
    chk("s6_rst_code", kp.key_code, 4'h0);
    pressed = '0;
    @(negedge clk50) sys_init_ctrl = 1'b0;
    repeat (10) @(posedge clk50);
    #1 chk("s6_scan_resumes", kp.col_n, 4'b1101);
    repeat (5) @(negedge clk50);
    chk("s6_no_pulse", dut_pulses - p0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
